// File: rtl/div_seq_pkg.sv
// Shared types and constants for the divider sequence controller.
package div_seq_pkg;

  localparam int unsigned N_STEPS = 4;
  localparam int unsigned DIV_W   = 3;
  localparam int unsigned LEN_W   = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [DIV_W-1:0] div;
    logic             ud;
    logic [LEN_W-1:0] len;
  } prog_entry_t;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for the divider's tick level.
module rise_detect (
  input  logic clk_i,
  input  logic clear_i,
  input  logic tick_i,
  output logic rise_o
);

  logic tick_d_q;

  // Remember the previous tick level so a 0->1 change can be seen
  always_ff @(posedge clk_i) begin
    if (clear_i) tick_d_q <= 1'b0;
    else         tick_d_q <= tick_i;
  end

  assign rise_o = tick_i & ~tick_d_q;

endmodule

// File: rtl/div_seq_ctrl.sv
// Program-table sequencer driving a clock divider and up/down counter.
module div_seq_ctrl #(
  parameter int unsigned N_STEPS = 4
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       start,
  input  logic       abort,
  input  logic       prog_we,
  input  logic [1:0] prog_addr,
  input  logic [2:0] prog_div,
  input  logic       prog_ud,
  input  logic [3:0] prog_len,
  input  logic       tick,
  output logic       cnt_clear,
  output logic [2:0] cnt_div,
  output logic       cnt_ud,
  output logic       cnt_en,
  output logic       busy,
  output logic       done,
  output logic [1:0] step
);

  import div_seq_pkg::*;

  state_t            state_q, state_d;
  logic [1:0]        step_q, step_d;
  logic [LEN_W-1:0]  tcnt_q, tcnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              ud_q, ud_d;
  logic              en_q, en_d;
  prog_entry_t       prog_q [N_STEPS];

  logic              rise;
  logic [LEN_W-1:0]  cur_len;
  prog_entry_t       nxt_e;
  logic              last_step;

  rise_detect u_rise (
    .clk_i   (clk),
    .clear_i (clear),
    .tick_i  (tick),
    .rise_o  (rise)
  );

  assign cur_len   = prog_q[step_q].len;
  assign nxt_e     = prog_q[step_q + 2'd1];
  assign last_step = (step_q == 2'(N_STEPS - 1)) || (nxt_e.len == '0);

  // Program table: writable only while the sequencer is not executing
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int unsigned i = 0; i < N_STEPS; i++) prog_q[i] <= '0;
    end else if (prog_we && (state_q == S_IDLE || state_q == S_DONE)) begin
      prog_q[prog_addr] <= {prog_div, prog_ud, prog_len};
    end
  end

  // Sequencer state and registered datapath controls
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      tcnt_q  <= '0;
      div_q   <= '0;
      ud_q    <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      tcnt_q  <= tcnt_d;
      div_q   <= div_d;
      ud_q    <= ud_d;
      en_q    <= en_d;
    end
  end

  // Next-state logic. The step-complete decision is taken in the cycle the
  // final cnt_en is high, so that pulse always lands in RUN with cnt_clear=0;
  // rises are at least two cycles apart, so no rise is lost by deferring it.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    tcnt_d  = tcnt_q;
    div_d   = div_q;
    ud_d    = ud_q;
    en_d    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (start) begin
          step_d = '0;
          if (prog_q[0].len != '0) begin
            state_d = S_LOAD;
            div_d   = prog_q[0].div;
            ud_d    = prog_q[0].ud;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        tcnt_d  = '0;
        state_d = abort ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (en_q && (tcnt_q == cur_len)) begin
          if (last_step) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
            step_d  = step_q + 2'd1;
            div_d   = nxt_e.div;
            ud_d    = nxt_e.ud;
          end
        end else if (rise) begin
          en_d   = 1'b1;
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cnt_clear = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign busy      = (state_q == S_LOAD) || (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign cnt_div   = div_q;
  assign cnt_ud    = ud_q;
  assign cnt_en    = en_q;
  assign step      = step_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl.
module tb_div_seq_ctrl;

  logic       clk = 1'b0;
  logic       clear = 1'b1, start = 1'b0, abort = 1'b0, prog_we = 1'b0;
  logic [1:0] prog_addr = '0;
  logic [2:0] prog_div = '0;
  logic       prog_ud = 1'b0;
  logic [3:0] prog_len = '0;
  logic       tick = 1'b0;
  logic       cnt_clear, cnt_ud, cnt_en, busy, done;
  logic [2:0] cnt_div;
  logic [1:0] step;

  div_seq_ctrl #(.N_STEPS(4)) dut (
    .clk(clk), .clear(clear), .start(start), .abort(abort),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_div(prog_div),
    .prog_ud(prog_ud), .prog_len(prog_len), .tick(tick),
    .cnt_clear(cnt_clear), .cnt_div(cnt_div), .cnt_ud(cnt_ud),
    .cnt_en(cnt_en), .busy(busy), .done(done), .step(step)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Transaction log of every count-enable pulse, plus done/LOAD cycle counts
  int         n_en = 0, n_done = 0, n_load = 0;
  logic [2:0] en_div  [4096];
  logic       en_ud   [4096];
  logic [1:0] en_step [4096];
  logic       en_clr  [4096];

  always @(negedge clk) begin
    if (cnt_en && n_en < 4096) begin
      en_div[n_en]  <= cnt_div;
      en_ud[n_en]   <= cnt_ud;
      en_step[n_en] <= step;
      en_clr[n_en]  <= cnt_clear;
      n_en          <= n_en + 1;
    end
    if (done) n_done <= n_done + 1;
    if (busy && cnt_clear) n_load <= n_load + 1;
  end

  typedef struct packed {
    logic       clear, start, abort, we;
    logic [1:0] addr;
    logic [2:0] div;
    logic       ud;
    logic [3:0] len;
    logic       tick;
    logic       e_clr;
    logic [2:0] e_div;
    logic       e_ud, e_en, e_busy, e_done;
    logic [1:0] e_step;
    logic       e_dc;   // cnt_div/cnt_ud not defined in this cycle
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(input int c, s, a, w, ad, dv, u, l, t,
                              input int ec, edv, eu, een, eb, ed, es, dc);
    vec_t v;
    v.clear = 1'(c);  v.start = 1'(s); v.abort = 1'(a); v.we = 1'(w);
    v.addr = 2'(ad);  v.div = 3'(dv);  v.ud = 1'(u);    v.len = 4'(l);
    v.tick = 1'(t);   v.e_clr = 1'(ec); v.e_div = 3'(edv); v.e_ud = 1'(eu);
    v.e_en = 1'(een); v.e_busy = 1'(eb); v.e_done = 1'(ed); v.e_step = 2'(es);
    v.e_dc = 1'(dc);
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1; start = 1'b0; abort = 1'b0; prog_we = 1'b0; tick = 1'b0;
    cyc();
    clear = 1'b0;
  endtask

  task automatic wr(input int a, input int dv, input int u, input int l);
    prog_we = 1'b1; prog_addr = 2'(a); prog_div = 3'(dv);
    prog_ud = 1'(u); prog_len = 4'(l);
    cyc();
    prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic run_until_done(input string nm, input bit rnd);
    int d0;
    d0 = n_done;
    for (int c = 0; c < 1500 && n_done == d0; c++) begin
      tick = rnd ? 1'($urandom_range(0, 1)) : 1'((c % 4) < 2);
      cyc();
    end
    tick = 1'b0;
    chk({nm, ".done_seen"}, n_done - d0, 1);
    cyc();
    cyc();
  endtask

  task automatic chk_pulse(input string nm, input int idx,
                           input int dv, input int u, input int st);
    chk($sformatf("%s.p%0d.div", nm, idx), int'(en_div[idx]), dv);
    chk($sformatf("%s.p%0d.ud", nm, idx), int'(en_ud[idx]), u);
    chk($sformatf("%s.p%0d.step", nm, idx), int'(en_step[idx]), st);
    chk($sformatf("%s.p%0d.clr", nm, idx), int'(en_clr[idx]), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b, l, d;
    int lens [4];
    int divs [4];
    int uds  [4];
    int ex_div [64];
    int ex_ud  [64];
    int ex_st  [64];
    int nx, nsteps, got;

    //        c s a w ad dv u l t   clr div ud en busy done step dc
    vecs[0]  = mk(1,0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0,0);
    vecs[1]  = mk(0,0,0,1,0,2,1,3,0, 1,0,0,0,0,0,0,0);
    vecs[2]  = mk(0,0,0,1,1,0,0,0,0, 1,0,0,0,0,0,0,0);
    vecs[3]  = mk(0,1,0,0,0,0,0,0,0, 1,2,1,0,1,0,0,0);
    vecs[4]  = mk(0,0,0,0,0,0,0,0,0, 0,2,1,0,1,0,0,0);
    vecs[5]  = mk(0,0,0,0,0,0,0,0,1, 0,2,1,1,1,0,0,0);
    vecs[6]  = mk(0,0,0,0,0,0,0,0,0, 0,2,1,0,1,0,0,0);
    vecs[7]  = mk(0,0,0,0,0,0,0,0,1, 0,2,1,1,1,0,0,0);
    vecs[8]  = mk(0,0,0,0,0,0,0,0,1, 0,2,1,0,1,0,0,0);
    vecs[9]  = mk(0,0,0,0,0,0,0,0,0, 0,2,1,0,1,0,0,0);
    vecs[10] = mk(0,0,0,0,0,0,0,0,1, 0,2,1,1,1,0,0,0);
    vecs[11] = mk(0,0,0,0,0,0,0,0,1, 0,2,1,0,0,1,0,0);
    vecs[12] = mk(0,0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0,1);
    vecs[13] = mk(0,0,0,1,0,0,0,0,0, 1,0,0,0,0,0,0,1);
    vecs[14] = mk(0,1,0,0,0,0,0,0,0, 0,0,0,0,0,1,0,1);
    vecs[15] = mk(0,0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0,1);

    // Reset, single-step program and empty program, one cycle per record
    for (int i = 0; i < 16; i++) begin
      clear = vecs[i].clear; start = vecs[i].start; abort = vecs[i].abort;
      prog_we = vecs[i].we; prog_addr = vecs[i].addr; prog_div = vecs[i].div;
      prog_ud = vecs[i].ud; prog_len = vecs[i].len; tick = vecs[i].tick;
      cyc();
      chk($sformatf("v%0d.cnt_clear", i), int'(cnt_clear), int'(vecs[i].e_clr));
      if (!vecs[i].e_dc) begin
        chk($sformatf("v%0d.cnt_div", i), int'(cnt_div), int'(vecs[i].e_div));
        chk($sformatf("v%0d.cnt_ud", i), int'(cnt_ud), int'(vecs[i].e_ud));
      end
      chk($sformatf("v%0d.cnt_en", i), int'(cnt_en), int'(vecs[i].e_en));
      chk($sformatf("v%0d.busy", i), int'(busy), int'(vecs[i].e_busy));
      chk($sformatf("v%0d.done", i), int'(done), int'(vecs[i].e_done));
      chk($sformatf("v%0d.step", i), int'(step), int'(vecs[i].e_step));
    end
    clear = 1'b0; start = 1'b0; prog_we = 1'b0; tick = 1'b0;

    // Two-step program
    do_clear();
    wr(0, 3, 1, 2);
    wr(1, 5, 0, 4);
    b = n_en; l = n_load;
    pulse_start();
    chk("two.load_busy", int'(busy), 1);
    chk("two.load_clr", int'(cnt_clear), 1);
    chk("two.load_div", int'(cnt_div), 3);
    chk("two.load_step", int'(step), 0);
    run_until_done("two", 1'b0);
    chk("two.pulses", n_en - b, 6);
    chk("two.load_cycles", n_load - l, 2);
    for (int k = 0; k < 6 && k < n_en - b; k++)
      chk_pulse("two", b + k, (k < 2) ? 3 : 5, (k < 2) ? 1 : 0, (k < 2) ? 0 : 1);
    chk("two.idle_clr", int'(cnt_clear), 1);
    chk("two.idle_busy", int'(busy), 0);

    // Abort mid-RUN with start and a tick rise in the same cycle
    do_clear();
    wr(0, 1, 0, 3);
    b = n_en; d = n_done;
    pulse_start();
    cyc();
    tick = 1'b1; cyc();
    tick = 1'b0; cyc();
    chk("abort.first_pulse", n_en - b, 1);
    abort = 1'b1; start = 1'b1; tick = 1'b1;
    cyc();
    abort = 1'b0; start = 1'b0;
    chk("abort.cnt_en", int'(cnt_en), 0);
    chk("abort.busy", int'(busy), 0);
    chk("abort.cnt_clear", int'(cnt_clear), 1);
    chk("abort.done", int'(done), 0);
    tick = 1'b0; cyc();
    tick = 1'b1; cyc();
    chk("abort.idle_rise_en", int'(cnt_en), 0);
    tick = 1'b0; cyc(); cyc();
    chk("abort.pulses", n_en - b, 1);
    chk("abort.no_done", n_done - d, 0);
    chk("abort.still_idle", int'(busy), 0);

    // Table write while busy is ignored
    do_clear();
    wr(0, 4, 1, 2);
    b = n_en;
    pulse_start();
    cyc();
    wr(0, 7, 0, 5);
    run_until_done("busywr1", 1'b0);
    chk("busywr1.pulses", n_en - b, 2);
    b = n_en;
    pulse_start();
    chk("busywr2.load_div", int'(cnt_div), 4);
    chk("busywr2.load_ud", int'(cnt_ud), 1);
    run_until_done("busywr2", 1'b0);
    chk("busywr2.pulses", n_en - b, 2);
    if (n_en - b > 0) chk_pulse("busywr2", b, 4, 1, 0);

    // Clear mid-RUN beats start, write and tick; table is wiped
    do_clear();
    wr(0, 6, 1, 5);
    wr(1, 2, 0, 3);
    pulse_start();
    cyc();
    tick = 1'b1; cyc();
    tick = 1'b0; cyc();
    clear = 1'b1; start = 1'b1; prog_we = 1'b1; prog_addr = 2'd1;
    prog_len = 4'd7; tick = 1'b1;
    cyc();
    clear = 1'b0; start = 1'b0; prog_we = 1'b0;
    chk("clr.cnt_clear", int'(cnt_clear), 1);
    chk("clr.cnt_div", int'(cnt_div), 0);
    chk("clr.cnt_ud", int'(cnt_ud), 0);
    chk("clr.cnt_en", int'(cnt_en), 0);
    chk("clr.busy", int'(busy), 0);
    chk("clr.done", int'(done), 0);
    chk("clr.step", int'(step), 0);
    tick = 1'b0;
    cyc();
    b = n_en;
    pulse_start();
    chk("clr.empty_done", int'(done), 1);
    chk("clr.empty_busy", int'(busy), 0);
    cyc();
    wr(0, 1, 1, 1);
    pulse_start();
    run_until_done("clr.entry1", 1'b0);
    chk("clr.entry1_pulses", n_en - b, 1);

    // Random programs and tick waveforms against a transaction-level model
    do_clear();
    for (int p = 0; p < 20; p++) begin
      for (int k = 0; k < 4; k++) begin
        divs[k] = int'($urandom_range(0, 7));
        uds[k]  = int'($urandom_range(0, 1));
        lens[k] = int'($urandom_range(0, 5));
      end
      lens[0] = (p % 6 == 5) ? 0 : int'($urandom_range(1, 5));
      for (int k = 0; k < 4; k++) wr(k, divs[k], uds[k], lens[k]);
      nx = 0; nsteps = 0;
      for (int k = 0; k < 4; k++) begin
        if (lens[k] == 0) break;
        nsteps++;
        for (int j = 0; j < lens[k]; j++) begin
          ex_div[nx] = divs[k]; ex_ud[nx] = uds[k]; ex_st[nx] = k;
          nx++;
        end
      end
      b = n_en; l = n_load;
      pulse_start();
      run_until_done($sformatf("rnd%0d", p), 1'b1);
      got = n_en - b;
      chk($sformatf("rnd%0d.pulses", p), got, nx);
      chk($sformatf("rnd%0d.loads", p), n_load - l, nsteps);
      for (int k = 0; k < nx && k < got; k++)
        chk_pulse($sformatf("rnd%0d", p), b + k, ex_div[k], ex_ud[k], ex_st[k]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_seq_ctrl.md
DIV_SEQ_CTRL -- requirements
Module: div_seq_ctrl

Interface
REQ-001 SHALL have parameter N_STEPS, default 4, number of program table entries (fixed at 4 for this release).
REQ-002 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-003 SHALL have port clear  in  1  reset; synchronous, active-high.
REQ-004 SHALL have port start  in  1  begin program execution from entry 0.
REQ-005 SHALL have port abort  in  1  stop execution and return to idle.
REQ-006 SHALL have port prog_we  in  1  table write strobe.
REQ-007 SHALL have port prog_addr  in  2  table entry index.
REQ-008 SHALL have port prog_div  in  3  divider ratio code for the entry.
REQ-009 SHALL have port prog_ud  in  1  count direction for the entry (1 = up).
REQ-010 SHALL have port prog_len  in  4  number of ticks for the entry (0 = end of program).
REQ-011 SHALL have port tick  in  1  divider output level, from the clock divider's q.
REQ-012 SHALL have port cnt_clear  out  1  clear to the divider and up/down counter.
REQ-013 SHALL have port cnt_div  out  3  ratio code to the divider.
REQ-014 SHALL have port cnt_ud  out  1  direction to the up/down counter.
REQ-015 SHALL have port cnt_en  out  1  one-cycle count-enable pulse per tick.
REQ-016 SHALL have ports busy (out, 1), done (out, 1) and step (out, 2); these report the active entry.

Function
REQ-017 SHALL provide the states IDLE, LOAD, RUN and DONE.
REQ-018 SHALL write table[prog_addr] <= {prog_div, prog_ud, prog_len} on prog_we only in IDLE or DONE; writes in LOAD/RUN are ignored.
REQ-019 SHALL go IDLE/DONE -> LOAD with step=0 on start when table[0].len != 0; if table[0].len == 0, SHALL go to DONE instead.
REQ-020 SHALL in LOAD, for exactly 1 cycle: drive cnt_clear=1, cnt_div=table[step].div, zero the tick count, then go to RUN.
REQ-021 SHALL in RUN: drive cnt_clear=0, cnt_div=table[step].div and cnt_ud=table[step].ud, all held stable.
REQ-022 SHALL detect a tick rise when tick=1 and the registered tick_d=0; SHALL honour rises only in RUN (rises in LOAD/IDLE are ignored).
REQ-023 SHALL assert cnt_en for exactly 1 cycle, in the cycle after the edge at which the rise was sampled; SHALL increment the 4-bit tick count on the same cycle.
REQ-024 SHALL act on the rise that makes tick count == table[step].len: if step==3 or table[step+1].len==0, go to DONE; else step+1 and go to LOAD.
REQ-025 SHALL in DONE: assert done=1 for 1 cycle, keep cnt_clear=0 and hold cnt_div/cnt_ud, then go to IDLE; a start during DONE SHALL restart per REQ-019.
REQ-026 SHALL assert busy=1 in LOAD and RUN, and 0 otherwise.
REQ-027 SHALL drive cnt_clear=1 in IDLE, holding the datapath cleared while unused.
REQ-028 SHALL on abort in LOAD/RUN/DONE go to IDLE next cycle with no further cnt_en; abort SHALL win over a simultaneous start or final tick.
REQ-029 SHALL ignore start in LOAD/RUN.
REQ-030 SHALL hold cnt_en=0 in the cycle following an abort, even if a rise was pending.

Reset
REQ-031 SHALL on clear=1 set: state=IDLE, step=0, tick count=0, tick_d=0, and all table entries to {div=0, ud=0, len=0}.
REQ-032 SHALL have these output values during and after clear: cnt_clear=1, cnt_div=0, cnt_ud=0, cnt_en=0, busy=0, done=0.
REQ-033 SHALL give clear priority over start, abort, prog_we and tick, including mid-RUN.

Structure
REQ-034 SHALL place in package div_seq_pkg: the state enum, a prog_entry_t struct {div[2:0], ud, len[3:0]}, N_STEPS, and the DIV_W=3 and LEN_W=4 constants.
REQ-035 SHALL implement tick rise detection (tick_d register plus rise output) as sub-module rise_detect.

Verification
REQ-036 SHALL cover single step: table[0]={2,1,3}, table[1].len=0, start -> LOAD 1 cycle with cnt_clear=1 and cnt_div=2; 3 tick rises -> 3 cnt_en pulses with cnt_ud=1; done 1 cycle; IDLE with cnt_clear=1.
REQ-037 SHALL cover two steps: {3,1,2} then {5,0,4} -> step 0->1, one LOAD between steps with cnt_div 3->5; 6 cnt_en pulses total; cnt_ud=0 during step 1.
REQ-038 SHALL cover an empty program: table[0].len=0, start -> DONE next cycle, busy stays 0, zero cnt_en.
REQ-039 SHALL cover abort mid-RUN after 1 of 3 ticks, with start asserted in the same cycle -> IDLE next cycle; a subsequent rise gives no cnt_en; done never asserts.
REQ-040 SHALL cover a write while busy: prog_we to entry 0 during RUN -> ignored; the next start uses the original values.
REQ-041 SHALL cover clear mid-RUN: clear=1 -> outputs per REQ-032 next cycle, and all table lengths read back as 0 (start -> DONE).
